// File: rtl/grid_cursor_pkg.sv
// grid_cursor_pkg: shared types and constants for the keypad grid cursor
package grid_cursor_pkg;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {S_IDLE, S_SEEK} state_t;
    localparam logic [23:0] DEC_MASK_DEFAULT = 24'hC3_3FFF;
endpackage

// File: rtl/grid_step.sv
// grid_step: one-cell combinational move on the grid with wrap or off-grid detection
module grid_step
    import grid_cursor_pkg::*;
#(
    parameter int COLS = 6,
    parameter int ROWS = 4,
    parameter int WRAP = 1,
    parameter int XW = $clog2(COLS),
    parameter int YW = $clog2(ROWS)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  dir_t          dir,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny,
    output logic          off_grid
);
    logic x_lo, x_hi, y_lo, y_hi;
    assign x_lo = x == '0;
    assign x_hi = x == XW'(COLS - 1);
    assign y_lo = y == '0;
    assign y_hi = y == YW'(ROWS - 1);
    // Step along dir; edges wrap modulo the grid, and in clamp mode flag the step off-grid
    always_comb begin
        nx = dir == DIR_LEFT ? (x_lo ? XW'(COLS - 1) : x - XW'(1)) :
             dir == DIR_RIGHT ? (x_hi ? '0 : x + XW'(1)) : x;
        ny = dir == DIR_UP ? (y_lo ? YW'(ROWS - 1) : y - YW'(1)) :
             dir == DIR_DOWN ? (y_hi ? '0 : y + YW'(1)) : y;
        off_grid = (WRAP == 0) && ((dir == DIR_LEFT && x_lo) || (dir == DIR_RIGHT && x_hi) ||
                                   (dir == DIR_UP && y_lo) || (dir == DIR_DOWN && y_hi));
    end
endmodule

// File: rtl/grid_cursor_seek.sv
// grid_cursor_seek: keypad grid cursor that skips forbidden cells one per clock
module grid_cursor_seek
    import grid_cursor_pkg::*;
#(
    parameter int COLS = 6,
    parameter int ROWS = 4,
    parameter logic [COLS*ROWS-1:0] HEX_MASK = '1,
    parameter logic [COLS*ROWS-1:0] DEC_MASK = DEC_MASK_DEFAULT,
    parameter int WRAP = 1,
    parameter int HOME_X = 0,
    parameter int HOME_Y = 0,
    parameter int XW = $clog2(COLS),
    parameter int YW = $clog2(ROWS),
    parameter int IW = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          dir_up,
    input  logic          dir_down,
    input  logic          dir_left,
    input  logic          dir_right,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [IW-1:0] cell_idx,
    output logic          busy,
    output logic          moved,
    output logic          blocked
);
    localparam int LMAX = COLS > ROWS ? COLS : ROWS;
    localparam int CW = $clog2(LMAX + 1);

    function automatic logic [IW-1:0] idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(y) * IW'(COLS) + IW'(x);
    endfunction

    state_t state, state_n;
    dir_t dir_q, dir_n, req, step_dir;
    logic [XW-1:0] pos_x_n, cand_x, cand_x_n, a_x, b_x;
    logic [YW-1:0] pos_y_n, cand_y, cand_y_n, a_y, b_y;
    logic [CW-1:0] cnt, cnt_n;
    logic [COLS*ROWS-1:0] mask;
    logic cand_off, cand_off_n, a_off, b_off, moved_n, blocked_n, mode_q;
    logic cur_ok, a_ok, cand_ok, last;

    assign mask = mode ? DEC_MASK : HEX_MASK;
    assign req = dir_up ? DIR_UP : dir_down ? DIR_DOWN : dir_left ? DIR_LEFT :
                 dir_right ? DIR_RIGHT : DIR_NONE;
    assign step_dir = state == S_SEEK ? dir_q : req;
    assign cur_ok = mask[idx(pos_x, pos_y)];
    assign a_ok = mask[idx(a_x, a_y)];
    assign cand_ok = mask[idx(cand_x, cand_y)];
    assign last = cnt == ((dir_q == DIR_UP || dir_q == DIR_DOWN) ? CW'(ROWS - 1) : CW'(COLS - 1));
    assign cell_idx = idx(pos_x, pos_y);
    assign busy = state == S_SEEK;

    // In IDLE the first step starts from pos; in SEEK it advances the pending candidate.
    // The second step provides the candidate to hold when the first lands on a forbidden cell.
    grid_step #(.COLS(COLS), .ROWS(ROWS), .WRAP(WRAP)) u_step_a (
        .x(state == S_SEEK ? cand_x : pos_x), .y(state == S_SEEK ? cand_y : pos_y),
        .dir(step_dir), .nx(a_x), .ny(a_y), .off_grid(a_off)
    );
    grid_step #(.COLS(COLS), .ROWS(ROWS), .WRAP(WRAP)) u_step_b (
        .x(a_x), .y(a_y), .dir(step_dir), .nx(b_x), .ny(b_y), .off_grid(b_off)
    );

    // State and output registers; mode is sampled to detect a change during a seek
    always_ff @(posedge clk) begin
        mode_q <= mode;
        if (rst) begin
            state <= S_IDLE;
            pos_x <= XW'(HOME_X);
            pos_y <= YW'(HOME_Y);
            cand_x <= '0;
            cand_y <= '0;
            cand_off <= 1'b0;
            dir_q <= DIR_NONE;
            cnt <= '0;
            moved <= 1'b0;
            blocked <= 1'b0;
        end else begin
            state <= state_n;
            pos_x <= pos_x_n;
            pos_y <= pos_y_n;
            cand_x <= cand_x_n;
            cand_y <= cand_y_n;
            cand_off <= cand_off_n;
            dir_q <= dir_n;
            cnt <= cnt_n;
            moved <= moved_n;
            blocked <= blocked_n;
        end
    end

    // Relocate, move, block or seek in IDLE; walk the candidate one cell per clock in SEEK
    always_comb begin
        state_n = state;
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        cand_x_n = cand_x;
        cand_y_n = cand_y;
        cand_off_n = cand_off;
        dir_n = dir_q;
        cnt_n = cnt;
        moved_n = 1'b0;
        blocked_n = 1'b0;
        if (state == S_IDLE) begin
            if (!cur_ok) begin
                pos_x_n = XW'(HOME_X);
                pos_y_n = YW'(HOME_Y);
                moved_n = 1'b1;
            end else if (req != DIR_NONE) begin
                if (a_off) begin
                    blocked_n = 1'b1;
                end else if (a_ok) begin
                    pos_x_n = a_x;
                    pos_y_n = a_y;
                    moved_n = 1'b1;
                end else begin
                    dir_n = req;
                    cand_x_n = b_x;
                    cand_y_n = b_y;
                    cand_off_n = b_off;
                    cnt_n = CW'(1);
                    state_n = S_SEEK;
                end
            end
        end else begin
            if (mode != mode_q) begin
                state_n = S_IDLE;
            end else if (!cand_off && cand_ok) begin
                pos_x_n = cand_x;
                pos_y_n = cand_y;
                moved_n = 1'b1;
                state_n = S_IDLE;
            end else if (cand_off || last) begin
                blocked_n = 1'b1;
                state_n = S_IDLE;
            end else begin
                cand_x_n = a_x;
                cand_y_n = a_y;
                cand_off_n = a_off;
                cnt_n = cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_grid_cursor_seek.sv
// tb_grid_cursor_seek: directed scoreboard bench for a wrapping and a clamping cursor
module tb_grid_cursor_seek;
    logic clk, rst, mode, dir_up, dir_down, dir_left, dir_right;
    logic [2:0] w_x, c_x;
    logic [1:0] w_y, c_y;
    logic [4:0] w_idx, c_idx;
    logic w_busy, w_moved, w_blocked, c_busy, c_moved, c_blocked;

    typedef struct {
        string      tag;
        bit         sel;
        logic [2:0] x;
        logic [1:0] y;
        logic       b, m, bl;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    grid_cursor_seek #(.WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .mode(mode), .dir_up(dir_up), .dir_down(dir_down),
        .dir_left(dir_left), .dir_right(dir_right), .pos_x(w_x), .pos_y(w_y),
        .cell_idx(w_idx), .busy(w_busy), .moved(w_moved), .blocked(w_blocked)
    );

    grid_cursor_seek #(.WRAP(0)) u_clamp (
        .clk(clk), .rst(rst), .mode(mode), .dir_up(dir_up), .dir_down(dir_down),
        .dir_left(dir_left), .dir_right(dir_right), .pos_x(c_x), .pos_y(c_y),
        .cell_idx(c_idx), .busy(c_busy), .moved(c_moved), .blocked(c_blocked)
    );

    always #5 clk = ~clk;

    task automatic ex(input bit sel, input string tag, input int x, input int y,
                      input logic b, input logic m, input logic bl);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.x = 3'(x);
        e.y = 2'(y);
        e.b = b;
        e.m = m;
        e.bl = bl;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        {dir_up, dir_down, dir_left, dir_right} = 4'b0;
        while (q.size() > 0) begin
            exp_t e;
            logic [12:0] got, want;
            e = q.pop_front();
            got = e.sel ? {c_x, c_y, c_idx, c_busy, c_moved, c_blocked}
                        : {w_x, w_y, w_idx, w_busy, w_moved, w_blocked};
            want = {e.x, e.y, 5'(int'(e.y) * 6 + int'(e.x)), e.b, e.m, e.bl};
            checks++;
            assert (got === want) else begin
                errors++;
                $error("FAIL %s observed x=%0d y=%0d idx=%0d busy=%b moved=%b blocked=%b expected x=%0d y=%0d idx=%0d busy=%b moved=%b blocked=%b",
                       e.tag, got[12:10], got[9:8], got[7:3], got[2], got[1], got[0],
                       want[12:10], want[9:8], want[7:3], want[2], want[1], want[0]);
            end
        end
    endtask

    task automatic st(input logic [3:0] p, input bit sel, input string tag, input int x,
                      input int y, input logic b, input logic m, input logic bl);
        {dir_up, dir_down, dir_left, dir_right} = p;
        ex(sel, tag, x, y, b, m, bl);
        cyc();
    endtask

    initial begin
        clk = 0;
        rst = 1;
        mode = 0;
        {dir_up, dir_down, dir_left, dir_right} = 4'b0;
        ex(1, "rst_c0", 0, 0, 0, 0, 0);
        st(4'b0000, 0, "rst_w0", 0, 0, 0, 0, 0);
        ex(1, "rst_c1", 0, 0, 0, 0, 0);
        st(4'b0000, 0, "rst_w1", 0, 0, 0, 0, 0);
        rst = 0;
        st(4'b0010, 0, "wrap_left", 5, 0, 0, 1, 0);
        st(4'b0000, 0, "hold", 5, 0, 0, 0, 0);
        st(4'b0001, 0, "wrap_right", 0, 0, 0, 1, 0);
        st(4'b1000, 0, "wrap_up", 0, 3, 0, 1, 0);
        st(4'b1000, 0, "up", 0, 2, 0, 1, 0);
        st(4'b0001, 0, "right", 1, 2, 0, 1, 0);
        mode = 1;
        st(4'b0001, 0, "seek_r_1", 1, 2, 1, 0, 0);
        st(4'b0100, 0, "seek_r_2", 1, 2, 1, 0, 0);
        st(4'b0000, 0, "seek_r_land", 4, 2, 0, 1, 0);
        st(4'b0000, 0, "seek_r_once", 4, 2, 0, 0, 0);
        st(4'b1000, 0, "dec_up", 4, 1, 0, 1, 0);
        st(4'b0010, 0, "dec_left", 3, 1, 0, 1, 0);
        st(4'b0010, 0, "dec_left2", 2, 1, 0, 1, 0);
        st(4'b0100, 0, "seek_d_1", 2, 1, 1, 0, 0);
        st(4'b0000, 0, "seek_d_2", 2, 1, 1, 0, 0);
        st(4'b0000, 0, "seek_d_land", 2, 0, 0, 1, 0);
        st(4'b0010, 0, "dec_left3", 1, 0, 0, 1, 0);
        st(4'b0010, 0, "dec_left4", 0, 0, 0, 1, 0);
        st(4'b1000, 0, "seek_u_1", 0, 0, 1, 0, 0);
        st(4'b0000, 0, "seek_u_land", 0, 2, 0, 1, 0);
        st(4'b0100, 0, "seek_d2_1", 0, 2, 1, 0, 0);
        st(4'b0000, 0, "seek_d2_land", 0, 0, 0, 1, 0);
        mode = 0;
        st(4'b1000, 0, "hex_up", 0, 3, 0, 1, 0);
        st(4'b0001, 0, "hex_r1", 1, 3, 0, 1, 0);
        st(4'b0001, 0, "hex_r2", 2, 3, 0, 1, 0);
        mode = 1;
        st(4'b0010, 0, "relocate", 0, 0, 0, 1, 0);
        st(4'b0000, 0, "relocate_q", 0, 0, 0, 0, 0);
        st(4'b0001, 0, "ab_r", 1, 0, 0, 1, 0);
        st(4'b0100, 0, "ab_d1", 1, 1, 0, 1, 0);
        st(4'b0100, 0, "ab_d2", 1, 2, 0, 1, 0);
        st(4'b0001, 0, "ab_seek", 1, 2, 1, 0, 0);
        mode = 0;
        st(4'b0000, 0, "ab_abort", 1, 2, 0, 0, 0);
        st(4'b0000, 0, "ab_idle", 1, 2, 0, 0, 0);
        mode = 1;
        st(4'b0001, 0, "rs_seek", 1, 2, 1, 0, 0);
        rst = 1;
        ex(1, "rs_c", 0, 0, 0, 0, 0);
        st(4'b0000, 0, "rs_w", 0, 0, 0, 0, 0);
        rst = 0;
        mode = 0;
        st(4'b0000, 1, "cl_idle", 0, 0, 0, 0, 0);
        st(4'b0100, 1, "cl_down", 0, 1, 0, 1, 0);
        st(4'b0010, 1, "cl_left_edge", 0, 1, 0, 0, 1);
        for (int i = 1; i <= 5; i++) st(4'b0001, 1, "cl_right", i, 1, 0, 1, 0);
        st(4'b0001, 1, "cl_right_edge", 5, 1, 0, 0, 1);
        st(4'b0000, 1, "cl_blk_once", 5, 1, 0, 0, 0);
        mode = 1;
        for (int i = 4; i >= 1; i--) st(4'b0010, 1, "cl_left", i, 1, 0, 1, 0);
        st(4'b0100, 1, "cl_down2", 1, 2, 0, 1, 0);
        st(4'b0100, 1, "cl_seek", 1, 2, 1, 0, 0);
        st(4'b0000, 1, "cl_seek_off", 1, 2, 0, 0, 1);
        st(4'b0000, 1, "cl_seek_q", 1, 2, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_cursor_seek.md
Name: grid_cursor_seek

Overview:
- Parametrised ROWS×COLS grid cursor for the VGA calculator keypad. It generalises the fixed 6×4 cursor.
- Per-mode allowed-cell masks replace hard-coded forbidden zones. A move skips over forbidden cells, stepping one cell per clock until it reaches an allowed cell.
- Edge handling is configurable: wrap-around or clamp.
- Sits between the pushbutton edge detectors and the grid renderer / key decoder, all on the VGA clock.

Parameters:
- COLS, 6, grid columns (≥2).
- ROWS, 4, grid rows (≥2).
- HEX_MASK, all ones (COLS*ROWS bits), allowed cells in mode 0; bit index = y*COLS+x.
- DEC_MASK, 24'hC3_3FFF, allowed cells in mode 1.
- WRAP, 1, 1 = wrap at edges, 0 = clamp.
- HOME_X, 0, relocation column; cell must be allowed in both masks.
- HOME_Y, 0, relocation row.

Ports:
- clk  in  1  clock (VGA pixel clock)
- rst  in  1  reset; synchronous, active-high
- mode  in  1  0 = HEX mask, 1 = DEC mask
- dir_up  in  1  one-cycle pulse, y−1
- dir_down  in  1  one-cycle pulse, y+1
- dir_left  in  1  one-cycle pulse, x−1
- dir_right  in  1  one-cycle pulse, x+1
- pos_x  out  XW=$clog2(COLS)  cursor column
- pos_y  out  YW=$clog2(ROWS)  cursor row
- cell_idx  out  $clog2(COLS*ROWS)  pos_y*COLS+pos_x; key-code mapping is downstream
- busy  out  1  seek in progress
- moved  out  1  one-cycle pulse, position changed this cycle
- blocked  out  1  one-cycle pulse, request produced no move

Behaviour:
- Reset: pos=(HOME_X,HOME_Y), state IDLE. busy, moved and blocked all 0. Reset has priority in any state, including mid-SEEK.
- Active mask = mode ? DEC_MASK : HEX_MASK, evaluated every cycle.
- Request priority (single axis per request): up > down > left > right. Lower-priority simultaneous pulses are discarded.
- Step function:
  - WRAP=1: modulo COLS or ROWS (x=COLS−1 +1 → 0; y=0 −1 → ROWS−1).
  - WRAP=0: a step off the edge is "off-grid".
- FSM IDLE:
  - Relocate check (highest priority): if the current cell is not allowed under the active mask, pos←HOME and moved=1 next cycle. Any direction pulse in that cycle is ignored.
  - Otherwise, on a request, compute cand=step(pos):
    - off-grid → blocked=1, stay IDLE;
    - allowed → pos←cand, moved=1 (1-cycle latency);
    - forbidden → latch dir, cand=step(cand), cnt=1, go to SEEK.
- FSM SEEK (busy=1):
  - Evaluate cand each cycle.
  - Allowed → pos←cand, moved=1, go to IDLE.
  - Forbidden or off-grid with cnt == LIMIT−1 (LIMIT = COLS for horizontal, ROWS for vertical), or off-grid (clamp) → blocked=1, pos unchanged, go to IDLE.
  - Otherwise cand=step(cand), cnt++.
  - Direction pulses are ignored while busy=1.
  - A mode change during SEEK aborts the seek: go to IDLE, and the relocate check applies on the next cycle.
- Latency: 1 + number of forbidden cells skipped, in clocks.
- Outputs are registered; cell_idx is combinational from the registers.

Decomposition:
- Package grid_cursor_pkg holds:
  - typedef dir_t {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - typedef state_t {S_IDLE, S_SEEK};
  - the default DEC_MASK constant.
- Sub-module grid_step: combinational step of (x, y, dir) returning the next x, y and an off_grid flag, parametrised by COLS, ROWS, WRAP.

Test Plan (COLS=6, ROWS=4, default masks unless noted):
1. rst high 2 cycles → pos=(0,0), cell_idx=0, busy=0, moved=0, blocked=0.
2. mode=0, WRAP=1, at (5,0), pulse right → next edge pos=(0,0), moved=1. Then pulse up → pos=(0,3).
3. mode=1, at (1,2), pulse right → busy=1 for 2 cycles; pos=(4,2) after 3rd edge, moved=1 once. A dir_down pulse during busy is ignored.
4. mode=1, at (2,1), pulse down → skips (2,2) and (2,3), lands on (2,0) after 3 edges. Same pulse from (0,2) → (0,0) after 2 edges.
5. mode=0, at (2,3), set mode=1 together with dir_left → next edge pos=(0,0), moved=1, left ignored.
6. WRAP=0, at (5,1), pulse right → blocked=1, pos unchanged. Assert rst during a SEEK → pos=(0,0), busy=0 next cycle.
